// File: rtl/vram_scanout_arbiter_if.sv
// Purpose: CPU request/response and VRAM bus bundle for vram_scanout_arbiter.
// Signals:
//   cpu_req/cpu_we/cpu_addr/cpu_wdata : CPU request, held stable until cpu_ack
//   cpu_ack                           : request granted this cycle
//   cpu_rvalid/cpu_rdata              : read return, one cycle after a read ack
//   mem_addr/mem_we/mem_wdata         : single-port VRAM command
//   mem_rdata                         : VRAM read data, 1-cycle latency
// Modports: slave = arbiter side, master = CPU + VRAM environment side.
interface vram_scanout_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned PIX_WIDTH  = 4
);
  localparam int unsigned WORD_WIDTH = 2 * PIX_WIDTH;

  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [WORD_WIDTH-1:0] cpu_wdata;
  logic                  cpu_ack;
  logic                  cpu_rvalid;
  logic [WORD_WIDTH-1:0] cpu_rdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [WORD_WIDTH-1:0] mem_wdata;
  logic [WORD_WIDTH-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output cpu_ack, cpu_rvalid, cpu_rdata, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_ack, cpu_rvalid, cpu_rdata, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vram_scanout_arbiter.sv
// Purpose: shares one single-port VRAM between raster scanout (absolute
// priority, one 2-pixel word fetched two clocks ahead of the beam) and a CPU
// requester that gets every non-video slot; also produces the current pixel.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   hpos, vpos  : beam position from the sync generator
//   bus         : CPU request/response and VRAM command/data (slave modport)
//   pix         : pixel at hpos/vpos, 0 outside the display area
module vram_scanout_arbiter #(
  parameter int unsigned H_DISPLAY  = 256,
  parameter int unsigned H_TOTAL    = 309,
  parameter int unsigned V_DISPLAY  = 240,
  parameter int unsigned V_TOTAL    = 262,
  parameter int unsigned POS_WIDTH  = 10,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned PIX_WIDTH  = 4,
  parameter int unsigned FB_BASE    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [POS_WIDTH-1:0] hpos,
  input  logic [POS_WIDTH-1:0] vpos,
  vram_scanout_arbiter_if.slave bus,
  output logic [PIX_WIDTH-1:0] pix
);
  localparam int unsigned WORD_WIDTH = 2 * PIX_WIDTH;
  localparam int unsigned EXT_WIDTH  = POS_WIDTH + 1;

  typedef logic [POS_WIDTH-1:0]  pos_t;
  typedef logic [EXT_WIDTH-1:0]  ext_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [WORD_WIDTH-1:0] word_t;

  localparam ext_t  H_TOTAL_X  = ext_t'(H_TOTAL);
  localparam ext_t  H_DISP_X   = ext_t'(H_DISPLAY);
  localparam pos_t  H_DISP_P   = pos_t'(H_DISPLAY);
  localparam pos_t  V_DISP_P   = pos_t'(V_DISPLAY);
  localparam pos_t  V_LAST_P   = pos_t'(V_TOTAL - 1);
  localparam pos_t  H_ROW_P    = pos_t'(H_TOTAL - 3);
  localparam addr_t ROW_STEP   = addr_t'(H_DISPLAY / 2);
  localparam addr_t BASE_ADDR  = addr_t'(FB_BASE);

  ext_t  hpos_ahead;
  ext_t  fx;
  pos_t  fline;
  logic  h_wrap;
  logic  video_slot;
  addr_t fetch_addr;

  logic  vid_pend;
  word_t vword;
  addr_t row_base;
  logic  rvalid_q;

  // Beam position two clocks ahead; decides whether this slot belongs to video.
  always_comb begin : lookahead
    hpos_ahead = ext_t'(hpos) + ext_t'(2);
    h_wrap     = (hpos_ahead >= H_TOTAL_X);
    fx         = h_wrap ? (hpos_ahead - H_TOTAL_X) : hpos_ahead;
    fline      = vpos;
    if (h_wrap) begin
      fline = (vpos == V_LAST_P) ? '0 : (vpos + pos_t'(1));
    end
    video_slot = !fx[0] && (fx < H_DISP_X) && (fline < V_DISP_P);
    fetch_addr = row_base + addr_t'(fx >> 1);
  end

  // Memory port mux: video owns its slots, CPU gets every other cycle.
  always_comb begin : mem_mux
    bus.cpu_ack   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    if (video_slot) begin
      bus.mem_addr = fetch_addr;
    end else if (bus.cpu_req && !reset) begin
      bus.cpu_ack = 1'b1;
      bus.mem_we  = bus.cpu_we;
    end
  end

  // Read-return flag, video word pipeline and line base address.
  always_ff @(posedge clk) begin : state_regs
    if (reset) begin
      rvalid_q <= 1'b0;
      vid_pend <= 1'b0;
      vword    <= '0;
      row_base <= BASE_ADDR;
    end else begin
      rvalid_q <= bus.cpu_ack && !bus.cpu_we;
      if (vid_pend) begin
        vword <= bus.mem_rdata;
      end
      vid_pend <= video_slot;
      // Advance just before the wrap slot fetches x=0 of the next line.
      if (hpos == H_ROW_P) begin
        row_base <= (vpos == V_LAST_P) ? BASE_ADDR : (row_base + ROW_STEP);
      end
    end
  end

  assign bus.cpu_rvalid = rvalid_q;
  assign bus.cpu_rdata  = rvalid_q ? bus.mem_rdata : '0;

  // Even columns show the low nibble of the word, odd columns the high one.
  always_comb begin : pixel_out
    pix = '0;
    if ((hpos < H_DISP_P) && (vpos < V_DISP_P)) begin
      pix = hpos[0] ? vword[WORD_WIDTH-1:PIX_WIDTH] : vword[PIX_WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_vram_scanout_arbiter.sv
// Purpose: self-checking bench for vram_scanout_arbiter. The bench acts as
// sync generator, CPU and VRAM; a reference model computes the expected
// fetch slots from the linear beam position and tracks memory contents.
// Ports of the DUT: clk, reset, hpos, vpos, bus (interface), pix.
module tb_vram_scanout_arbiter;
  localparam int unsigned H_DISPLAY  = 256;
  localparam int unsigned H_TOTAL    = 309;
  localparam int unsigned V_DISPLAY  = 240;
  localparam int unsigned V_TOTAL    = 262;
  localparam int unsigned POS_WIDTH  = 10;
  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned PIX_WIDTH  = 4;
  localparam int unsigned FB_BASE    = 0;
  localparam int unsigned FRAME      = H_TOTAL * V_TOTAL;
  localparam logic [15:0] MARK       = 16'hBEEF;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [POS_WIDTH-1:0] hpos;
  logic [POS_WIDTH-1:0] vpos;
  logic [PIX_WIDTH-1:0] pix;

  vram_scanout_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH), .PIX_WIDTH(PIX_WIDTH)) bus ();

  vram_scanout_arbiter #(
    .H_DISPLAY(H_DISPLAY), .H_TOTAL(H_TOTAL), .V_DISPLAY(V_DISPLAY),
    .V_TOTAL(V_TOTAL), .POS_WIDTH(POS_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .PIX_WIDTH(PIX_WIDTH), .FB_BASE(FB_BASE)
  ) dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .bus(bus), .pix(pix)
  );

  always #5 clk = ~clk;

  // VRAM environment: synchronous single port, read-before-write.
  logic [7:0] vram [0:65535];
  always @(posedge clk) begin
    if (bus.mem_we) vram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= vram[bus.mem_addr];
  end

  // Reference model state.
  logic [7:0] ram_m [0:65535];
  int         row_m = 0;
  bit         pend_m = 1'b0;
  logic [7:0] pend_d = 8'h00;
  logic [7:0] vword_m = 8'h00;
  bit         rvalid_m = 1'b0;
  logic [7:0] rdata_m = 8'h00;

  int nchk = 0;
  int nerr = 0;
  int gh = 0;
  int gv = 0;
  bit gen_run = 1'b0;
  bit rand_cpu = 1'b0;
  bit ack_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s at v=%0d h=%0d observed=%0h expected=%0h", tag, gv, gh, obs, exp);
    end
  endtask

  // Video slot from the linear beam position two clocks ahead.
  function automatic bit model_video(input int v, input int h, output int fa);
    int p;
    int fx;
    int fl;
    p = v * int'(H_TOTAL) + h + 2;
    if (p >= int'(FRAME)) p = p - int'(FRAME);
    fx = p % int'(H_TOTAL);
    fl = p / int'(H_TOTAL);
    fa = (int'(FB_BASE) + row_m * int'(H_DISPLAY / 2) + fx / 2) % 65536;
    return (fx % 2 == 0) && (fx < int'(H_DISPLAY)) && (fl < int'(V_DISPLAY));
  endfunction

  task automatic new_req();
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'($urandom_range(0, 1));
    bus.cpu_addr  = 16'(16'h0100 + $urandom_range(0, 511));
    bus.cpu_wdata = 8'($urandom);
  endtask

  // One clock: check at negedge, update model at posedge, then drive inputs.
  task automatic tick();
    bit         vid;
    int         fa;
    bit         e_ack;
    logic [3:0] e_pix;
    @(negedge clk);
    vid   = model_video(gv, gh, fa);
    e_ack = bus.cpu_req && !reset && !vid;
    chk("cpu_ack", 32'(bus.cpu_ack), 32'(e_ack));
    chk("mem_we", 32'(bus.mem_we), 32'(e_ack && bus.cpu_we));
    chk("mem_addr", 32'(bus.mem_addr), vid ? 32'(fa) : 32'(bus.cpu_addr));
    if (e_ack && bus.cpu_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(bus.cpu_wdata));
    chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(rvalid_m));
    if (rvalid_m) chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(rdata_m));
    e_pix = 4'h0;
    if (gh < int'(H_DISPLAY) && gv < int'(V_DISPLAY))
      e_pix = (gh % 2 == 1) ? vword_m[7:4] : vword_m[3:0];
    chk("pix", 32'(pix), 32'(e_pix));
    ack_seen = bus.cpu_ack;
    @(posedge clk);
    if (reset) begin
      rvalid_m = 1'b0;
      pend_m   = 1'b0;
      vword_m  = 8'h00;
      row_m    = 0;
    end else begin
      rvalid_m = e_ack && !bus.cpu_we;
      rdata_m  = ram_m[bus.cpu_addr];
      if (pend_m) vword_m = pend_d;
      pend_m = vid;
      pend_d = ram_m[16'(fa)];
      if (gh == int'(H_TOTAL) - 3) row_m = (gv == int'(V_TOTAL) - 1) ? 0 : row_m + 1;
    end
    if (e_ack && bus.cpu_we) ram_m[bus.cpu_addr] = bus.cpu_wdata;
    #1;
    if (gen_run) begin
      gh++;
      if (gh == int'(H_TOTAL)) begin
        gh = 0;
        gv++;
        if (gv == int'(V_TOTAL)) gv = 0;
      end
    end
    hpos = POS_WIDTH'(gh);
    vpos = POS_WIDTH'(gv);
    if (rand_cpu) begin
      if (!bus.cpu_req || ack_seen) begin
        if ($urandom_range(0, 99) < 60) new_req();
        else bus.cpu_req = 1'b0;
      end
    end else if (ack_seen) begin
      bus.cpu_req  = 1'b0;
      bus.cpu_addr = MARK;
    end
  endtask

  task automatic run_to(input int v, input int h);
    int budget;
    budget = 90000;
    while (!(gv == v && gh == h) && budget > 0) begin
      tick();
      budget--;
    end
    nchk++;
    assert (budget > 0) else begin
      nerr++;
      $error("FAIL run_to v=%0d h=%0d observed=timeout expected=reached", v, h);
    end
    #1;
  endtask

  task automatic jump(input int v, input int h);
    gv   = v;
    gh   = h;
    hpos = POS_WIDTH'(gh);
    vpos = POS_WIDTH'(gv);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      vram[i]  = 8'($urandom);
      ram_m[i] = vram[i];
    end
    vram[128]   = 8'hA5; ram_m[128]   = 8'hA5;
    vram[16'h42] = 8'h3C; ram_m[16'h42] = 8'h3C;

    reset = 1'b1;
    hpos = '0;
    vpos = '0;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = MARK;
    bus.cpu_wdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    bus.cpu_req = 1'b1;
    bus.cpu_we  = 1'b1;
    #1;
    chk("rst_ack", 32'(bus.cpu_ack), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    chk("rst_pix", 32'(pix), 32'd0);
    tick();
    bus.cpu_req = 1'b0;
    bus.cpu_addr = MARK;
    reset = 1'b0;
    gen_run = 1'b1;

    // First line after reset, CPU idle.
    #1;
    chk("v0h0_addr", 32'(bus.mem_addr), 32'd1);
    chk("v0h0_we", 32'(bus.mem_we), 32'd0);
    run_to(0, 252); chk("v0h252_addr", 32'(bus.mem_addr), 32'd127);
    run_to(0, 254); chk("v0h254_nofetch", 32'(bus.mem_addr), 32'(MARK));
    run_to(0, 307); chk("v0h307_addr", 32'(bus.mem_addr), 32'd128);
    run_to(1, 0);   chk("v1h0_pix", 32'(pix), 32'h5);
    run_to(1, 1);   chk("v1h1_pix", 32'(pix), 32'hA);
    run_to(1, 256); chk("v1h256_pix", 32'(pix), 32'h0);
    run_to(1, 308); chk("v1h308_pix", 32'(pix), 32'h0);

    // Random CPU traffic across display lines.
    rand_cpu = 1'b1;
    run_to(4, 300);
    rand_cpu = 1'b0;
    run_to(5, 10);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0123; bus.cpu_wdata = 8'h5A;
    #1;
    chk("wr_h10_ack", 32'(bus.cpu_ack), 32'd0);
    tick();
    #1;
    chk("wr_h11_ack", 32'(bus.cpu_ack), 32'd1);
    chk("wr_h11_we", 32'(bus.mem_we), 32'd1);
    chk("wr_h11_addr", 32'(bus.mem_addr), 32'h0123);
    chk("wr_h11_wdata", 32'(bus.mem_wdata), 32'h5A);
    rand_cpu = 1'b1;
    run_to(7, 300);
    rand_cpu = 1'b0;
    run_to(8, 0);

    // Last visible line: wrap slot must not fetch line 240.
    jump(238, 0);
    run_to(239, 307); chk("v239h307_nofetch", 32'(bus.mem_addr), 32'(MARK));

    // Blanking read, then back-to-back random traffic.
    jump(245, 95);
    run_to(245, 100);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0042;
    #1;
    chk("rd_h100_ack", 32'(bus.cpu_ack), 32'd1);
    chk("rd_h100_we", 32'(bus.mem_we), 32'd0);
    tick();
    #1;
    chk("rd_h101_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    chk("rd_h101_rdata", 32'(bus.cpu_rdata), 32'h3C);
    rand_cpu = 1'b1;
    run_to(246, 300);
    rand_cpu = 1'b0;

    // Frame wrap.
    jump(260, 0);
    rand_cpu = 1'b1;
    run_to(261, 290);
    rand_cpu = 1'b0;
    run_to(261, 307); chk("v261h307_addr", 32'(bus.mem_addr), 32'd0);
    run_to(261, 308); chk("v261h308_vid_pend", 32'(dut.vid_pend), 32'd1);
    rand_cpu = 1'b1;
    run_to(1, 300);
    rand_cpu = 1'b0;

    // Reset for two cycles with a write request held during display.
    run_to(2, 10);
    reset = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0200; bus.cpu_wdata = 8'h77;
    #1;
    chk("rst_h10_ack", 32'(bus.cpu_ack), 32'd0);
    tick();
    #1;
    chk("rst_h11_ack", 32'(bus.cpu_ack), 32'd0);
    chk("rst_h11_we", 32'(bus.mem_we), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rel_h12_ack", 32'(bus.cpu_ack), 32'd0);
    tick();
    #1;
    chk("rel_h13_ack", 32'(bus.cpu_ack), 32'd1);
    chk("rel_h13_addr", 32'(bus.mem_addr), 32'h0200);
    chk("rel_h13_we", 32'(bus.mem_we), 32'd1);
    rand_cpu = 1'b1;
    run_to(4, 0);
    rand_cpu = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/vram_scanout_arbiter.md
Name: vram_scanout_arbiter

Overview:
- Shares one single-port synchronous video RAM between two users: the raster scanout, which takes hpos/vpos from the sync generator, and a CPU-side requester.
- Scanout has absolute priority. It fetches one 2-pixel word per pair of pixels, one word ahead of the beam.
- The CPU gets every other memory slot.
- Also produces the pixel value for the current beam position.

Parameters:
- H_DISPLAY, 256: visible pixels per line. Must be even.
- H_TOTAL, 309: clocks per line (hpos runs 0..H_TOTAL-1).
- V_DISPLAY, 240: visible lines.
- V_TOTAL, 262: lines per frame.
- POS_WIDTH, 10: width of hpos/vpos.
- ADDR_WIDTH, 16: VRAM word address width.
- PIX_WIDTH, 4: bits per pixel. VRAM word = 2*PIX_WIDTH.
- FB_BASE, 0: word address of line 0, pixel 0.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high.
- hpos, in, POS_WIDTH: beam column from the sync generator.
- vpos, in, POS_WIDTH: beam line from the sync generator.
- cpu_req, in, 1: CPU access request. Held with addr/we/wdata stable until cpu_ack.
- cpu_we, in, 1: 1 = write, 0 = read.
- cpu_addr, in, ADDR_WIDTH: CPU word address.
- cpu_wdata, in, 2*PIX_WIDTH: write data.
- cpu_ack, out, 1: request granted this cycle.
- cpu_rvalid, out, 1: cpu_rdata valid (read only).
- cpu_rdata, out, 2*PIX_WIDTH: read data.
- mem_addr, out, ADDR_WIDTH: VRAM address.
- mem_we, out, 1: VRAM write enable.
- mem_wdata, out, 2*PIX_WIDTH: VRAM write data.
- mem_rdata, in, 2*PIX_WIDTH: VRAM read data, 1-cycle latency after address.
- pix, out, PIX_WIDTH: pixel for the current hpos/vpos. 0 outside the display area.

Behaviour:
- Lookahead:
  - fx = hpos+2 if hpos+2 < H_TOTAL, else hpos+2-H_TOTAL.
  - fline = vpos if no wrap. On wrap, fline = vpos+1, or 0 when vpos == V_TOTAL-1.
- Video slot = fx even AND fx < H_DISPLAY AND fline < V_DISPLAY. Evaluated every cycle (combinational).
- Video slot cycle:
  - mem_addr = row_base + fx/2, mem_we = 0.
  - cpu_ack = 0.
  - vid_pend <= 1.
- Non-video cycle:
  - cpu_ack = cpu_req & ~reset (combinational).
  - If acked: mem_addr = cpu_addr, mem_we = cpu_we, mem_wdata = cpu_wdata.
  - If not acked: mem_we = 0, mem_addr = don't-care (drive cpu_addr).
- Slot rates:
  - During active fetch the CPU waits at most 1 cycle.
  - In blanking the CPU is acked every cycle it requests.
  - Back-to-back CPU requests are allowed.
- Read return: cpu_rvalid <= (cpu_ack & ~cpu_we). cpu_rdata = mem_rdata while cpu_rvalid is high.
- Video load: in the cycle after a video slot (vid_pend = 1), vword <= mem_rdata, vid_pend <= 0.
- row_base register (ADDR_WIDTH, modulo 2^ADDR_WIDTH):
  - Holds the word address of the line being fetched.
  - At hpos == H_TOTAL-3: row_base <= FB_BASE if vpos == V_TOTAL-1, else row_base + H_DISPLAY/2.
  - Lines at or beyond V_DISPLAY keep advancing but issue no fetches.
- Pixel output:
  - pix = (hpos < H_DISPLAY && vpos < V_DISPLAY) ? (hpos[0] ? vword[2P-1:P] : vword[P-1:0]) : 0.
  - Pixel x (even) is fetched at hpos x-2, loaded at x-1, displayed at x and x+1.
- Reset values: cpu_rvalid 0, vid_pend 0, vword 0, row_base FB_BASE. cpu_ack and mem_we forced 0 while reset is high.
- Reset mid-operation:
  - An unacked CPU request is not served during reset. If req is still held, it is served on the first eligible cycle after reset.
  - A read acked in the cycle before reset: cpu_rvalid is cleared and the data is lost.
- After reset, when the generator restarts at (0,0), line-0 pixels 0–1 show 0 for the first frame; fetch for x=0 was skipped. This is accepted behaviour.
- Simultaneous CPU request on a video slot: video wins, and the CPU is acked the next cycle.

Test Plan:
- Reset, then sweep hpos/vpos with defaults and cpu_req=0:
  - at (v0,h0): mem_addr = 1;
  - at (v0,h252): mem_addr = 127;
  - at (v0,h254): no fetch;
  - at (v0,h307): mem_addr = 128 (line 1, x0).
- Frame wrap:
  - at (v261,h307): mem_addr = 0 and vid_pend set;
  - at (v239,h307): no fetch, because fline = 240.
- CPU write, req raised at (v5,h10) (video slot, fx=12): cpu_ack=0 at h10; cpu_ack=1 at h11 with mem_we=1 and addr/wdata passed through.
- CPU read in blanking at (v245,h100), addr 0x0042 holding 0x3C: cpu_ack at h100, then cpu_rvalid=1 and cpu_rdata=0x3C at h101.
- VRAM word 128 = 0xA5:
  - line 1: pix=5 at h0, pix=A at h1;
  - h256–308: pix=0.
- Reset asserted for 2 cycles while cpu_req=1 held during display: no ack during reset; ack on the first non-video cycle after release.
